// File: rtl/guess_game_core_if.sv
// Player-facing port bundle for guess_game_core: button levels and guess in, game status out.
// The master side (player / test harness) drives the buttons; the slave side is the core.
interface guess_game_core_if #(
    parameter int VAL_W = 4
);
    logic             start;
    logic             submit;
    logic [VAL_W-1:0] guess;
    logic [2:0]       state_o;
    logic [1:0]       hint;
    logic [3:0]       lives;
    logic [7:0]       win_cnt;
    logic [7:0]       loss_cnt;

    modport master (
        output start, submit, guess,
        input  state_o, hint, lives, win_cnt, loss_cnt
    );

    modport slave (
        input  start, submit, guess,
        output state_o, hint, lives, win_cnt, loss_cnt
    );
endinterface

// File: rtl/guess_game_core.sv
// Number-guessing game engine: LFSR secret, higher/lower hints, lives and saturating scores.
// Optional idle timeout in WAIT is enabled by defining GG_TIMEOUT_EN.
module guess_game_core #(
    parameter int          VAL_W       = 4,
    parameter int          LIVES       = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          TIMEOUT_CYC = 1000
) (
    input  logic             CLK,
    input  logic             CLR,
    guess_game_core_if.slave gg
);

    if (VAL_W < 1 || VAL_W > 16) begin : g_bad_val_w
        $error("guess_game_core: VAL_W must be 1..16");
    end
    if (LIVES < 1 || LIVES > 15) begin : g_bad_lives
        $error("guess_game_core: LIVES must be 1..15");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("guess_game_core: LFSR_SEED must be non-zero");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("guess_game_core: TIMEOUT_CYC must be 1..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CMP  = 3'd3,
        ST_WIN  = 3'd4,
        ST_LOSE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [VAL_W-1:0] secret_q, secret_d;
    logic [VAL_W-1:0] guess_q, guess_d;
    logic [1:0]       hint_q, hint_d;
    logic [3:0]       lives_q, lives_d;
    logic [7:0]       win_cnt_q, win_cnt_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic             start_prev_q, start_prev_d;
    logic             submit_prev_q, submit_prev_d;
    logic             start_edge, submit_edge;
    logic [3:0]       lives_dec;
    logic [7:0]       win_inc, loss_inc;

`ifdef GG_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] timer_q, timer_d;
`endif

    assign start_edge  = gg.start & ~start_prev_q;
    assign submit_edge = gg.submit & ~submit_prev_q;
    assign lives_dec   = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
    assign win_inc     = (win_cnt_q != 8'hFF) ? win_cnt_q + 8'd1 : win_cnt_q;
    assign loss_inc    = (loss_cnt_q != 8'hFF) ? loss_cnt_q + 8'd1 : loss_cnt_q;

    always_comb begin
        state_d       = state_q;
        secret_d      = secret_q;
        guess_d       = guess_q;
        hint_d        = hint_q;
        lives_d       = lives_q;
        win_cnt_d     = win_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        start_prev_d  = gg.start;
        submit_prev_d = gg.submit;
        // Fibonacci taps 16,14,13,11 (bits 15,13,12,10), free-running
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        if (start_edge) begin
            state_d = ST_ARM;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARM: begin
                    secret_d = lfsr_q[VAL_W-1:0];
                    lives_d  = 4'(LIVES);
                    hint_d   = 2'b00;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (submit_edge) begin
                        guess_d = gg.guess;
                        state_d = ST_CMP;
                    end
`ifdef GG_TIMEOUT_EN
                    else if (timer_q == TO_LAST) begin
                        hint_d  = 2'b00;
                        lives_d = lives_dec;
                        if (lives_q <= 4'd1) begin
                            loss_cnt_d = loss_inc;
                            state_d    = ST_LOSE;
                        end
                    end
`endif
                end
                ST_CMP: begin
                    if (guess_q == secret_q) begin
                        hint_d    = 2'b11;
                        win_cnt_d = win_inc;
                        state_d   = ST_WIN;
                    end else begin
                        hint_d  = (guess_q < secret_q) ? 2'b01 : 2'b10;
                        lives_d = lives_dec;
                        if (lives_q <= 4'd1) begin
                            loss_cnt_d = loss_inc;
                            state_d    = ST_LOSE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WIN, ST_LOSE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef GG_TIMEOUT_EN
    // Counts only while idling in WAIT; any exit, submit or expiry restarts from zero.
    always_comb begin
        timer_d = 16'd0;
        if (state_q == ST_WAIT && !start_edge && !submit_edge && timer_q != TO_LAST) begin
            timer_d = timer_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= LFSR_SEED;
            secret_q      <= '0;
            guess_q       <= '0;
            hint_q        <= 2'b00;
            lives_q       <= 4'd0;
            win_cnt_q     <= 8'd0;
            loss_cnt_q    <= 8'd0;
            start_prev_q  <= 1'b1;
            submit_prev_q <= 1'b1;
`ifdef GG_TIMEOUT_EN
            timer_q       <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            secret_q      <= secret_d;
            guess_q       <= guess_d;
            hint_q        <= hint_d;
            lives_q       <= lives_d;
            win_cnt_q     <= win_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            start_prev_q  <= start_prev_d;
            submit_prev_q <= submit_prev_d;
`ifdef GG_TIMEOUT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    assign gg.state_o  = state_q;
    assign gg.hint     = hint_q;
    assign gg.lives    = lives_q;
    assign gg.win_cnt  = win_cnt_q;
    assign gg.loss_cnt = loss_cnt_q;

endmodule
